// File: rtl/apb_cmd_master22.sv
// Single-outstanding APB master front end: a valid/ready command in, SETUP/ACCESS on the bus,
// and a valid/ready response out, with a programmable ACCESS-phase watchdog.
module apb_cmd_master22 #(
  parameter int PADDR_WIDTH22    = 32,
  parameter int PWDATA_WIDTH22   = 32,
  parameter int PRDATA_WIDTH22   = 32,
  parameter int TIMEOUT_CYCLES22 = 256
) (
  input  logic                      pclock22,
  input  logic                      preset22,

  input  logic                      cmd_valid22,
  output logic                      cmd_ready22,
  input  logic [PADDR_WIDTH22-1:0]  cmd_addr22,
  input  logic                      cmd_write22,
  input  logic [PWDATA_WIDTH22-1:0] cmd_wdata22,
  input  logic [3:0]                cmd_sel22,

  output logic                      rsp_valid22,
  input  logic                      rsp_ready22,
  output logic [PRDATA_WIDTH22-1:0] rsp_rdata22,
  output logic                      rsp_err22,
  output logic                      rsp_timeout22,

  output logic [PADDR_WIDTH22-1:0]  paddr22,
  output logic                      prwd22,
  output logic [PWDATA_WIDTH22-1:0] pwdata22,
  output logic [15:0]               psel22,
  output logic                      penable22,
  input  logic                      pready22,
  input  logic [PRDATA_WIDTH22-1:0] prdata22,
  input  logic                      pslverr22
);

  // A disabled watchdog still needs a 1-bit counter so the declarations stay legal.
  localparam int CW = (TIMEOUT_CYCLES22 > 0) ? $clog2(TIMEOUT_CYCLES22 + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES22);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                sel_q, sel_d;
  logic [CW-1:0]             cnt_q, cnt_d, cnt_inc;
  logic [PADDR_WIDTH22-1:0]  paddr_d;
  logic                      prwd_d;
  logic [PWDATA_WIDTH22-1:0] pwdata_d;
  logic [15:0]               psel_d;
  logic                      penable_d;
  logic                      rsp_valid_d;
  logic [PRDATA_WIDTH22-1:0] rsp_rdata_d;
  logic                      rsp_err_d;
  logic                      rsp_timeout_d;

  assign cmd_ready22 = (state_q == ST_IDLE) && !preset22;
  assign cnt_inc     = cnt_q + CW'(1);

  always_ff @(posedge pclock22) begin
    if (preset22) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      paddr22       <= '0;
      prwd22        <= 1'b0;
      pwdata22      <= '0;
      psel22        <= '0;
      penable22     <= 1'b0;
      rsp_valid22   <= 1'b0;
      rsp_rdata22   <= '0;
      rsp_err22     <= 1'b0;
      rsp_timeout22 <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      paddr22       <= paddr_d;
      prwd22        <= prwd_d;
      pwdata22      <= pwdata_d;
      psel22        <= psel_d;
      penable22     <= penable_d;
      rsp_valid22   <= rsp_valid_d;
      rsp_rdata22   <= rsp_rdata_d;
      rsp_err22     <= rsp_err_d;
      rsp_timeout22 <= rsp_timeout_d;
    end
  end

  // Next values are computed one cycle ahead so every bus and response output is registered.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr22;
    prwd_d        = prwd22;
    pwdata_d      = pwdata22;
    psel_d        = psel22;
    penable_d     = penable22;
    rsp_valid_d   = rsp_valid22;
    rsp_rdata_d   = rsp_rdata22;
    rsp_err_d     = rsp_err22;
    rsp_timeout_d = rsp_timeout22;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid22) begin
          paddr_d   = cmd_addr22;
          prwd_d    = cmd_write22;
          pwdata_d  = cmd_wdata22;
          sel_d     = cmd_sel22;
          psel_d    = 16'd1 << cmd_sel22;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d     = '0;
        psel_d    = 16'd1 << sel_q;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready22) begin
          rsp_err_d     = pslverr22;
          rsp_rdata_d   = (!prwd22 && !pslverr22) ? prdata22 : '0;
          rsp_timeout_d = 1'b0;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT_CYCLES22 != 0) && (cnt_inc == TIMEOUT_VAL)) begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            psel_d        = '0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready22) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_cmd_master22.sv
// Directed bench for apb_cmd_master22: table of transfers plus reset, backpressure and
// mid-ACCESS reset sequences, with the watchdog set to 4 cycles.
module tb_apb_cmd_master22;

  logic        pclock22 = 1'b0;
  logic        preset22;
  logic        cmd_valid22;
  logic        cmd_ready22;
  logic [31:0] cmd_addr22;
  logic        cmd_write22;
  logic [31:0] cmd_wdata22;
  logic [3:0]  cmd_sel22;
  logic        rsp_valid22;
  logic        rsp_ready22;
  logic [31:0] rsp_rdata22;
  logic        rsp_err22;
  logic        rsp_timeout22;
  logic [31:0] paddr22;
  logic        prwd22;
  logic [31:0] pwdata22;
  logic [15:0] psel22;
  logic        penable22;
  logic        pready22;
  logic [31:0] prdata22;
  logic        pslverr22;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          wait_n;
    logic        slverr;
    logic [31:0] prdata;
    logic [15:0] exp_psel;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  apb_cmd_master22 #(
    .PADDR_WIDTH22(32),
    .PWDATA_WIDTH22(32),
    .PRDATA_WIDTH22(32),
    .TIMEOUT_CYCLES22(4)
  ) dut (
    .pclock22(pclock22),
    .preset22(preset22),
    .cmd_valid22(cmd_valid22),
    .cmd_ready22(cmd_ready22),
    .cmd_addr22(cmd_addr22),
    .cmd_write22(cmd_write22),
    .cmd_wdata22(cmd_wdata22),
    .cmd_sel22(cmd_sel22),
    .rsp_valid22(rsp_valid22),
    .rsp_ready22(rsp_ready22),
    .rsp_rdata22(rsp_rdata22),
    .rsp_err22(rsp_err22),
    .rsp_timeout22(rsp_timeout22),
    .paddr22(paddr22),
    .prwd22(prwd22),
    .pwdata22(pwdata22),
    .psel22(psel22),
    .penable22(penable22),
    .pready22(pready22),
    .prdata22(prdata22),
    .pslverr22(pslverr22)
  );

  always #5 pclock22 = ~pclock22;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Runs one transfer with the slave raising pready after wait_n low ACCESS cycles,
  // then holds rsp_ready low for hold cycles before accepting the response.
  task automatic applyStimulus(input vec_t v, input int hold);
    int  lat;
    bit  done;
    logic [31:0] held_rdata;
    lat  = 0;
    done = 0;
    @(negedge pclock22);
    cmd_valid22 = 1'b1;
    cmd_addr22  = v.addr;
    cmd_write22 = v.write;
    cmd_wdata22 = v.wdata;
    cmd_sel22   = v.sel;
    checkOutput({v.name, "/cmd_ready_idle"}, 32'(cmd_ready22), 32'd1);
    for (int j = 1; j <= 20 && !done; j++) begin
      @(negedge pclock22);
      cmd_valid22 = 1'b0;
      pready22    = 1'b0;
      pslverr22   = 1'b1;
      prdata22    = 32'hFFFF_FFFF;
      if (rsp_valid22) begin
        done = 1;
        lat  = j;
      end else if (j == 1) begin
        checkOutput({v.name, "/setup_psel"}, 32'(psel22), 32'(v.exp_psel));
        checkOutput({v.name, "/setup_penable"}, 32'(penable22), 32'd0);
        checkOutput({v.name, "/setup_paddr"}, paddr22, v.addr);
        checkOutput({v.name, "/setup_prwd"}, 32'(prwd22), 32'(v.write));
        checkOutput({v.name, "/setup_pwdata"}, pwdata22, v.wdata);
        checkOutput({v.name, "/setup_cmd_ready"}, 32'(cmd_ready22), 32'd0);
      end else begin
        checkOutput({v.name, "/access_penable"}, 32'(penable22), 32'd1);
        checkOutput({v.name, "/access_psel"}, 32'(psel22), 32'(v.exp_psel));
        if (j - 2 == v.wait_n) begin
          pready22  = 1'b1;
          pslverr22 = v.slverr;
          prdata22  = v.prdata;
        end
      end
    end
    pready22  = 1'b0;
    pslverr22 = 1'b0;
    checkOutput({v.name, "/latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({v.name, "/rsp_rdata"}, rsp_rdata22, v.exp_rdata);
    checkOutput({v.name, "/rsp_err"}, 32'(rsp_err22), 32'(v.exp_err));
    checkOutput({v.name, "/rsp_timeout"}, 32'(rsp_timeout22), 32'(v.exp_to));
    checkOutput({v.name, "/resp_psel"}, 32'(psel22), 32'd0);
    checkOutput({v.name, "/resp_penable"}, 32'(penable22), 32'd0);
    held_rdata = v.exp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge pclock22);
      checkOutput({v.name, "/hold_valid"}, 32'(rsp_valid22), 32'd1);
      checkOutput({v.name, "/hold_rdata"}, rsp_rdata22, held_rdata);
      checkOutput({v.name, "/hold_err"}, 32'(rsp_err22), 32'(v.exp_err));
      checkOutput({v.name, "/hold_cmd_ready"}, 32'(cmd_ready22), 32'd0);
      checkOutput({v.name, "/hold_psel"}, 32'(psel22), 32'd0);
    end
    rsp_ready22 = 1'b1;
    @(negedge pclock22);
    rsp_ready22 = 1'b0;
    checkOutput({v.name, "/post_rsp_valid"}, 32'(rsp_valid22), 32'd0);
    checkOutput({v.name, "/post_cmd_ready"}, 32'(cmd_ready22), 32'd1);
    checkOutput({v.name, "/post_paddr_hold"}, paddr22, v.addr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t bp;
    vecs[0] = '{"wr_zero_wait", 32'h0000_0100, 1'b1, 32'hA5A5_0001, 4'd3, 0, 1'b0, 32'h1234_5678,
                16'h0008, 32'h0, 1'b0, 1'b0, 3};
    vecs[1] = '{"rd_two_wait", 32'h0000_0204, 1'b0, 32'h0, 4'd15, 2, 1'b0, 32'hDEAD_BEEF,
                16'h8000, 32'hDEAD_BEEF, 1'b0, 1'b0, 5};
    vecs[2] = '{"rd_slverr", 32'h0000_0010, 1'b0, 32'h0, 4'd0, 0, 1'b1, 32'hCAFE_F00D,
                16'h0001, 32'h0, 1'b1, 1'b0, 3};
    vecs[3] = '{"rd_timeout", 32'h0000_0ABC, 1'b0, 32'h0, 4'd7, 99, 1'b0, 32'h5555_AAAA,
                16'h0080, 32'h0, 1'b1, 1'b1, 6};
    vecs[4] = '{"rd_ready_4th", 32'h0000_0300, 1'b0, 32'h0, 4'd5, 3, 1'b0, 32'h0BAD_C0DE,
                16'h0020, 32'h0BAD_C0DE, 1'b0, 1'b0, 6};
    vecs[5] = '{"wr_slverr", 32'h0000_0400, 1'b1, 32'h7777_0001, 4'd9, 1, 1'b1, 32'h1111_2222,
                16'h0200, 32'h0, 1'b1, 1'b0, 4};

    preset22    = 1'b1;
    cmd_valid22 = 1'b0;
    cmd_addr22  = '0;
    cmd_write22 = 1'b0;
    cmd_wdata22 = '0;
    cmd_sel22   = '0;
    rsp_ready22 = 1'b0;
    pready22    = 1'b0;
    prdata22    = '0;
    pslverr22   = 1'b0;

    // Reset state
    repeat (2) @(negedge pclock22);
    checkOutput("reset/cmd_ready", 32'(cmd_ready22), 32'd0);
    checkOutput("reset/psel", 32'(psel22), 32'd0);
    checkOutput("reset/penable", 32'(penable22), 32'd0);
    checkOutput("reset/paddr", paddr22, 32'd0);
    checkOutput("reset/rsp_valid", 32'(rsp_valid22), 32'd0);
    checkOutput("reset/rsp_err", 32'(rsp_err22), 32'd0);
    preset22 = 1'b0;
    @(negedge pclock22);
    checkOutput("reset/cmd_ready_after", 32'(cmd_ready22), 32'd1);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 0);

    // Response backpressure for 10 cycles on a read so the held data is non-zero
    bp = '{"backpressure", 32'h0000_0500, 1'b0, 32'h0, 4'd2, 0, 1'b0, 32'h1357_9BDF,
           16'h0004, 32'h1357_9BDF, 1'b0, 1'b0, 3};
    applyStimulus(bp, 10);

    // Reset in the middle of ACCESS abandons the transfer
    @(negedge pclock22);
    cmd_valid22 = 1'b1;
    cmd_addr22  = 32'h0000_0600;
    cmd_write22 = 1'b1;
    cmd_wdata22 = 32'h9999_8888;
    cmd_sel22   = 4'd4;
    @(negedge pclock22);
    cmd_valid22 = 1'b0;
    @(negedge pclock22);
    checkOutput("midrst/access_penable", 32'(penable22), 32'd1);
    preset22 = 1'b1;
    @(negedge pclock22);
    checkOutput("midrst/psel", 32'(psel22), 32'd0);
    checkOutput("midrst/penable", 32'(penable22), 32'd0);
    checkOutput("midrst/paddr", paddr22, 32'd0);
    checkOutput("midrst/prwd", 32'(prwd22), 32'd0);
    checkOutput("midrst/pwdata", pwdata22, 32'd0);
    checkOutput("midrst/rsp_valid", 32'(rsp_valid22), 32'd0);
    checkOutput("midrst/rsp_rdata", rsp_rdata22, 32'd0);
    checkOutput("midrst/rsp_err", 32'(rsp_err22), 32'd0);
    checkOutput("midrst/rsp_timeout", 32'(rsp_timeout22), 32'd0);
    checkOutput("midrst/cmd_ready_in_reset", 32'(cmd_ready22), 32'd0);
    preset22 = 1'b0;
    @(negedge pclock22);
    checkOutput("midrst/cmd_ready_after", 32'(cmd_ready22), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge pclock22);
      checkOutput("midrst/no_response", 32'(rsp_valid22), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master22.md
# apb_cmd_master22

Single-outstanding APB master front end. It accepts a transfer command on a valid/ready request port, runs the APB SETUP and ACCESS phases on the master-side APB signals (paddr, prwd, pwdata, psel, penable, pready, prdata, pslverr), and returns read data and an error flag on a valid/ready response port. It sits directly upstream of the APB master interface and is the only driver of its bus signals. A programmable watchdog ends ACCESS phases that never complete.

## Interface

**Parameters**
- PADDR_WIDTH22, 32, address width.
- PWDATA_WIDTH22, 32, write data width.
- PRDATA_WIDTH22, 32, read data width.
- TIMEOUT_CYCLES22, 256, maximum number of ACCESS cycles before the block forces an error. 0 disables the watchdog. The counter width is clog2(TIMEOUT_CYCLES22+1).

**Ports**

Clock and reset:
- pclock22, in, 1, the single clock. All logic is on its rising edge.
- preset22, in, 1, synchronous, active-high reset.

Command port:
- cmd_valid22, in, 1, command present.
- cmd_ready22, out, 1, block can accept a command.
- cmd_addr22, in, PADDR_WIDTH22, target address.
- cmd_write22, in, 1, 1 = write, 0 = read.
- cmd_wdata22, in, PWDATA_WIDTH22, write data.
- cmd_sel22, in, 4, slave index, decoded to one-hot psel22.

Response port:
- rsp_valid22, out, 1, response present.
- rsp_ready22, in, 1, consumer accepts the response.
- rsp_rdata22, out, PRDATA_WIDTH22, read data. 0 for writes and for errors.
- rsp_err22, out, 1, set for pslverr22 or a timeout.
- rsp_timeout22, out, 1, set only when the error was caused by the watchdog.

APB bus:
- paddr22, out, PADDR_WIDTH22.
- prwd22, out, 1.
- pwdata22, out, PWDATA_WIDTH22.
- psel22, out, 16.
- penable22, out, 1.
- pready22, in, 1.
- prdata22, in, PRDATA_WIDTH22.
- pslverr22, in, 1.

## Operation

The FSM has four states: IDLE, SETUP, ACCESS, RESP.

- **IDLE**
  - cmd_ready22 = 1, except while preset22 is high, when it is 0.
  - When cmd_valid22 is high, capture addr, write, wdata and sel into paddr22, prwd22, pwdata22 and a sel register, then go to SETUP.
- **SETUP**
  - psel22 = 1<<sel, penable22 = 0. Clear the watchdog counter.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - psel22 stays asserted, penable22 = 1.
  - pready22 = 1: capture rsp_err22 = pslverr22. Capture rsp_rdata22 = prdata22 only for a read with pslverr22 = 0; otherwise rsp_rdata22 = 0. Set rsp_timeout22 = 0, go to RESP.
  - pready22 = 0: increment the counter. If TIMEOUT_CYCLES22 != 0 and the incremented count equals TIMEOUT_CYCLES22, set rsp_err22 = 1, rsp_timeout22 = 1, rsp_rdata22 = 0, and go to RESP.
  - If pready22 = 1 on the same cycle as the timeout, pready22 wins.
- **RESP**
  - psel22 = 0, penable22 = 0, rsp_valid22 = 1.
  - When rsp_ready22 is high, go to IDLE.

Bus signal rules:
- paddr22, prwd22 and pwdata22 change only on command capture. They hold their last values in IDLE and RESP.
- prdata22 and pslverr22 are ignored except in ACCESS with pready22 = 1.
- cmd_ready22 is 0 in SETUP, ACCESS and RESP. There is never more than one transfer outstanding.

Reset (preset22 = 1, sampled at the clock edge):
- State goes to IDLE. This holds in any state; an in-flight transfer is abandoned and no response is produced.
- Reset values: psel22 = 0, penable22 = 0, paddr22 = 0, prwd22 = 0, pwdata22 = 0, rsp_valid22 = 0, rsp_rdata22 = 0, rsp_err22 = 0, rsp_timeout22 = 0, cmd_ready22 = 0.
- Counter = 0.

## Timing

- Command handshake at edge N, then:
  - SETUP during cycle N+1.
  - First ACCESS cycle during N+2.
- Zero-wait slave (pready22 = 1 in N+2): rsp_valid22 = 1 from N+3.
- Each low pready22 cycle in ACCESS adds one cycle of latency.
- Response handshake at edge M: IDLE in M+1, and cmd_ready22 = 1 in M+1. The minimum command-to-command spacing is 4 cycles.
- Timeout with TIMEOUT_CYCLES22 = T: ACCESS lasts exactly T cycles; rsp_valid22 rises in the following cycle.
- All outputs are registered, except cmd_ready22, which decodes from state and preset22.
- cmd_* inputs are don't-care whenever cmd_ready22 = 0.

## Test plan

- **Write, zero wait:** cmd addr = 0x100, write = 1, wdata = 0xA5A5_0001, sel = 3.
  - psel22 = 0x0008 in SETUP, penable22 = 1 one cycle later.
  - Response: rsp_err22 = 0, rsp_rdata22 = 0, rsp_valid22 3 cycles after the command handshake.
- **Read, 2 wait states:** sel = 15, prdata22 = 0xDEAD_BEEF with pready22 high in the third ACCESS cycle.
  - psel22 = 0x8000.
  - Response: rsp_rdata22 = 0xDEAD_BEEF, rsp_err22 = 0, latency 5 cycles.
- **Slave error:** read with pslverr22 = 1 and pready22 = 1.
  - Response: rsp_err22 = 1, rsp_timeout22 = 0, rsp_rdata22 = 0.
- **Timeout:** TIMEOUT_CYCLES22 = 4 with pready22 held 0.
  - Exactly 4 ACCESS cycles.
  - Response: rsp_err22 = 1, rsp_timeout22 = 1. Then pready22 = 1 on the 4th cycle: normal completion with rsp_timeout22 = 0.
- **Response backpressure:** hold rsp_ready22 = 0 for 10 cycles.
  - rsp_valid22 and the response data stay stable; cmd_ready22 = 0; psel22 = 0.
  - After rsp_ready22 goes high, cmd_ready22 = 1 in the next cycle.
- **Reset mid-ACCESS:** assert preset22 for 1 cycle.
  - Next cycle: all bus outputs and response outputs are 0, no response is issued, and cmd_ready22 = 1 after preset22 falls.
